// File: rtl/celem_vote_array.sv
// celem_vote_array: registered GROUPS x LANES C-element cell matrix with lane/group/global
// majority reduction, a persistence filter on the global vote and a rising-edge counter.
module celem_vote_array #(
  parameter int GROUPS = 3,
  parameter int LANES  = 3,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     clr,
  input  logic [1:0]               mode,
  input  logic [GROUPS-1:0]        sel,
  input  logic [GROUPS*LANES-1:0]  din,
  input  logic [HOLD_W-1:0]        hold,
  output logic [GROUPS*LANES-1:0]  cells,
  output logic [LANES-1:0]         lane_any,
  output logic [GROUPS-1:0]        grp_maj,
  output logic                     any,
  output logic                     vote,
  output logic                     vote_stable,
  output logic [CNT_W-1:0]         edge_count,
  output logic                     edge_ovf
);
  localparam int N = GROUPS * LANES;
  logic [N-1:0]      cells_q, cells_d;
  logic [HOLD_W-1:0] stab_q, stab_d;
  logic [CNT_W-1:0]  ecnt_q, ecnt_d;
  logic              vs_q, vs_d, ovf_q, ovf_d, rise;
  for (genvar g = 0; g < GROUPS; g++) begin : g_row
    for (genvar l = 0; l < LANES; l++) begin : g_col
      localparam int I = g * LANES + l;
      logic a, b, c;
      assign a = sel[g];
      assign b = din[I];
      assign c = cells_q[I];
      assign cells_d[I] = clr ? 1'b0 :
                          mode == 2'd0 ? (a & b) | ((a | b) & c) :
                          mode == 2'd1 ? c | (a & b) :
                          mode == 2'd2 ? a & b : c;
    end
  end
  // Strict majority: popcount*2 > N, so even-width ties resolve to 0.
  always_comb begin
    int pop;
    pop = 0;
    lane_any = '0;
    grp_maj = '0;
    for (int i = 0; i < GROUPS; i++) begin
      pop = 0;
      for (int j = 0; j < LANES; j++) begin
        lane_any[j] = lane_any[j] | cells_q[i*LANES+j];
        pop = pop + int'(cells_q[i*LANES+j]);
      end
      grp_maj[i] = pop * 2 > LANES;
    end
    pop = 0;
    for (int j = 0; j < LANES; j++) pop = pop + int'(lane_any[j]);
    vote = pop * 2 > LANES;
  end
  assign any = |lane_any;
  // Filter sees the pre-clear vote, since vote derives from cells_q.
  always_comb begin
    stab_d = (vote == vs_q || stab_q == hold) ? '0 : stab_q + 1'b1;
    vs_d   = (vote != vs_q && stab_q == hold) ? vote : vs_q;
    rise   = vs_d & ~vs_q;
    ecnt_d = ecnt_q + CNT_W'(rise);
    ovf_d  = ovf_q | (rise & (&ecnt_q));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cells_q <= '0;
      stab_q  <= '0;
      vs_q    <= 1'b0;
      ecnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (ena) begin
      cells_q <= cells_d;
      stab_q  <= stab_d;
      vs_q    <= vs_d;
      ecnt_q  <= ecnt_d;
      ovf_q   <= ovf_d;
    end
  end
  assign cells       = cells_q;
  assign vote_stable = vs_q;
  assign edge_count  = ecnt_q;
  assign edge_ovf    = ovf_q;
endmodule

// File: doc/celem_vote_array.md
# celem_vote_array

Parametrised, clocked successor to the Tiny Tapeout Muller C-element voting matrix. It holds a GROUPS×LANES array of registered state cells, each combining one group select with one lane data bit under a selectable cell mode. Per-lane OR, per-group majority and global majority are reduced from the cell array. A programmable persistence filter and an edge counter sit on the global vote. It is instantiated inside a `tt_um_` wrapper that maps its ports onto `ui_in`/`uio_in`/`uo_out`.

## Interface
- GROUPS, default 3: number of group select lines (rows).
- LANES, default 3: cells per group (columns).
- HOLD_W, default 4: width of the persistence threshold and counter.
- CNT_W, default 8: width of the vote edge counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  update enable; low freezes all state (reset still acts).
- clr  in  1  synchronous clear of the cell array (qualified by ena).
- mode  in  2  cell mode: 0 C-element, 1 sticky-set, 2 transparent, 3 freeze.
- sel  in  GROUPS  group select; sel[g] is the common input of group g.
- din  in  GROUPS*LANES  lane data; din[g*LANES+l] pairs with sel[g].
- hold  in  HOLD_W  persistence threshold.
- cells  out  GROUPS*LANES  cell state registers, same indexing as din.
- lane_any  out  LANES  lane_any[l] = OR over g of cell[g][l].
- grp_maj  out  GROUPS  grp_maj[g] = strict majority of cell[g][*].
- any  out  1  OR of lane_any.
- vote  out  1  strict majority of lane_any.
- vote_stable  out  1  persistence-filtered vote.
- edge_count  out  CNT_W  count of vote_stable 0→1 transitions, wraps.
- edge_ovf  out  1  sticky; set when edge_count wraps from all-ones to 0.

## Operation
- Cell next state, with a = sel[g], b = din[g*LANES+l], c = current state:
  - mode 0: c' = a&b | (a|b)&c. Sets when both inputs are high, clears when both are low, holds otherwise.
  - mode 1: c' = c | a&b. Never clears except through clr or reset.
  - mode 2: c' = a&b.
  - mode 3: c' = c.
- clr=1 with ena=1: all cells go to 0, overriding mode. This happens on the same edge.
- Strict majority: popcount*2 > N. For even N, a tie gives 0. With N=1 the majority equals the single input.
- lane_any, grp_maj, any and vote are combinational from the cell registers. There are no input-to-output combinational paths.
- Persistence filter, with internal stab_cnt of HOLD_W bits:
  - vote == vote_stable: stab_cnt <= 0.
  - vote != vote_stable and stab_cnt == hold: vote_stable <= vote and stab_cnt <= 0.
  - otherwise: stab_cnt <= stab_cnt+1.
  - The result is that vote_stable changes after vote has differed on hold+1 consecutive edges.
- Edge counter:
  - On an edge where vote_stable goes 0→1, edge_count <= edge_count+1, modulo 2^CNT_W.
  - If edge_count was all-ones, edge_ovf <= 1. edge_ovf clears only on reset.
- Changing hold mid-count: the comparison uses the current hold each cycle. If stab_cnt > hold, the counter keeps counting until it wraps. Software must clear by forcing vote == vote_stable or by reset; this is a documented limitation.
- ena=0: cells, stab_cnt, vote_stable, edge_count and edge_ovf all hold. clr is ignored. Combinational outputs still track the held cells.

## Timing
- Reset (rst_n low at an edge):
  - all cells, stab_cnt, vote_stable, edge_count and edge_ovf become 0.
  - all outputs therefore read 0 after that edge.
  - Reset takes priority over ena and clr.
- Input to cells: 1 edge. Input to vote: 1 edge.
- Input to vote_stable: hold+2 edges.
- vote_stable to edge_count: edge_count updates on the same edge that vote_stable rises.
- Reset released mid-operation: the first edge with rst_n high evaluates normally from the all-zero state.
- Simultaneous clr and vote_stable pending: the filter uses the pre-clear vote on that edge. The cleared array is seen on the next edge.

## Test plan
- Reset: drive random inputs, rst_n=0 for 1 edge -> every output is 0. Release -> a state change appears only after the next edge.
- C-element hold, mode 0, hold=0:
  - sel=001, din[2:0]=111 -> next edge: cells[2:0]=111, lane_any=111, grp_maj=001, vote=1.
  - Then vote_stable=1 and edge_count=1 one edge later.
  - sel=000 with din=111 -> cells hold.
  - din=000 -> cells[2:0]=000 and vote=0.
- Sticky vs transparent:
  - mode 1: pulse sel=010, din[5:3]=011 for one cycle -> cells[5:3]=011 persist after the inputs drop.
  - mode 2 with the same pulse -> the cells clear one edge after the inputs drop.
  - clr=1 -> all cells 0.
- Persistence filter, hold=2:
  - vote high for 2 cycles -> vote_stable stays 0 and edge_count is unchanged.
  - vote high for 3 cycles -> vote_stable rises on the 3rd differing edge and edge_count increments by 1.
- Wrap (CNT_W=4): 16 filtered rising events -> edge_count=0 and edge_ovf=1. A 17th event -> edge_count=1 and edge_ovf stays 1.
- ena=0 for 5 cycles with toggling inputs and clr=1 -> cells, vote_stable and edge_count are unchanged. ena=1 resumes normal behaviour.
